sc_cs_sequencer: RTL and testbench

//  Microsequencer for the control store (CS). Every cycle it chooses the next 11-bit CS address from one of:
//  the increment of the current address, the microword jump field, or the opcode decode address.
//  The choice depends on the microword COND field and the ALU flags.
//  It sits between the microword register and the CS ROM, and owns the CS address register and its incrementer.
//  It adds a run/halt/trap control FSM and a retired-microinstruction counter for the datapath.

---
 rtl/sc_cs_pkg.sv | 38 +++
 rtl/sc_cs_sequencer_if.sv | 34 +++
 rtl/sc_cs_branch_eval.sv | 42 ++++
 rtl/sc_cs_sequencer.sv | 123 ++++++++++++
 tb/tb_sc_cs_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_cs_pkg.sv
// Shared encodings for the control-store microsequencer: COND field codes,
// FSM states, and the decode address prefix.
package sc_cs_pkg;

    localparam int CSADDR_W = 11;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_BR_N   = 3'b001,
        COND_BR_Z   = 3'b010,
        COND_BR_V   = 3'b011,
        COND_BR_C   = 3'b100,
        COND_BR_IR  = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Bit positions inside the {N,Z,V,C} flag bus
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic DECODE_PREFIX = 1'b1;

    typedef struct packed {
        logic sel_next;
        logic sel_jump;
        logic sel_decode;
    } addr_sel_t;

endpackage

// File: rtl/sc_cs_sequencer_if.sv
// Handshake/bus bundle between the microword/datapath side (master) and the
// sequencer (slave).
interface sc_cs_sequencer_if #(
    parameter int CSADDR_W = 11,
    parameter int COUNT_W  = 16
);
    logic                CSSEQ_START_InHigh;
    logic                CSSEQ_HALT_InHigh;
    logic                CSSEQ_TRAP_InHigh;
    logic                CSSEQ_STALL_InHigh;
    logic [2:0]          CSSEQ_COND_InBUS;
    logic [CSADDR_W-1:0] CSSEQ_JUMPADDR_InBUS;
    logic [31:0]         CSSEQ_IR_InBUS;
    logic [3:0]          CSSEQ_FLAGS_InBUS;
    logic [CSADDR_W-1:0] CSSEQ_CSADDR_OutBUS;
    logic                CSSEQ_VALID_OutHigh;
    logic [1:0]          CSSEQ_STATE_OutBUS;
    logic                CSSEQ_WRAP_OutHigh;
    logic [COUNT_W-1:0]  CSSEQ_COUNT_OutBUS;

    modport master (
        output CSSEQ_START_InHigh, CSSEQ_HALT_InHigh, CSSEQ_TRAP_InHigh, CSSEQ_STALL_InHigh,
        output CSSEQ_COND_InBUS, CSSEQ_JUMPADDR_InBUS, CSSEQ_IR_InBUS, CSSEQ_FLAGS_InBUS,
        input  CSSEQ_CSADDR_OutBUS, CSSEQ_VALID_OutHigh, CSSEQ_STATE_OutBUS,
        input  CSSEQ_WRAP_OutHigh, CSSEQ_COUNT_OutBUS
    );

    modport slave (
        input  CSSEQ_START_InHigh, CSSEQ_HALT_InHigh, CSSEQ_TRAP_InHigh, CSSEQ_STALL_InHigh,
        input  CSSEQ_COND_InBUS, CSSEQ_JUMPADDR_InBUS, CSSEQ_IR_InBUS, CSSEQ_FLAGS_InBUS,
        output CSSEQ_CSADDR_OutBUS, CSSEQ_VALID_OutHigh, CSSEQ_STATE_OutBUS,
        output CSSEQ_WRAP_OutHigh, CSSEQ_COUNT_OutBUS
    );
endinterface

// File: rtl/sc_cs_branch_eval.sv
// Combinational COND decode: picks increment, jump field or opcode decode
// address for the next control-store fetch.
module sc_cs_branch_eval
    import sc_cs_pkg::*;
(
    input  logic [2:0]          cond,
    input  logic [3:0]          flags,
    input  logic                ir_bit13,
    input  logic [1:0]          ir_class,
    input  logic [5:0]          ir_op,
    output addr_sel_t           sel,
    output logic [CSADDR_W-1:0] decode_addr
);

    logic take_branch;

    always_comb begin
        take_branch = 1'b0;
        sel         = '{sel_next: 1'b0, sel_jump: 1'b0, sel_decode: 1'b0};
        case (cond_e'(cond))
            COND_BR_N:   take_branch = flags[FLAG_N];
            COND_BR_Z:   take_branch = flags[FLAG_Z];
            COND_BR_V:   take_branch = flags[FLAG_V];
            COND_BR_C:   take_branch = flags[FLAG_C];
            COND_BR_IR:  take_branch = ir_bit13;
            COND_JUMP:   take_branch = 1'b1;
            default:     take_branch = 1'b0;
        endcase

        if (cond_e'(cond) == COND_DECODE) begin
            sel.sel_decode = 1'b1;
        end else if (take_branch) begin
            sel.sel_jump = 1'b1;
        end else begin
            sel.sel_next = 1'b1;
        end
    end

    // Decode lands on 4-word aligned entry points in the upper half of the store
    assign decode_addr = {DECODE_PREFIX, ir_class, ir_op, 2'b00};

endmodule

// File: rtl/sc_cs_sequencer.sv
// Control-store microsequencer: run/halt/trap FSM, CS address register with
// incrementer, sticky wrap flag and saturating retired-microinstruction counter.
module sc_cs_sequencer
    import sc_cs_pkg::*;
#(
    parameter int                    DATAWIDTH_CSADDR = 11,
    parameter int                    DATAWIDTH_COUNT  = 16,
    parameter logic [DATAWIDTH_CSADDR-1:0] TRAP_VECTOR = 11'h7F0
)(
    input  logic           SC_CSSEQ_CLOCK_50,
    input  logic           SC_CSSEQ_RESET_InHigh,
    sc_cs_sequencer_if.slave bus
);

    state_e                      state_reg, state_next;
    logic [DATAWIDTH_CSADDR-1:0] csaddr_reg, csaddr_next;
    logic [DATAWIDTH_COUNT-1:0]  count_reg;
    logic                        wrap_reg;

    logic load_zero, load_trap, load_seq, count_en, valid;

    addr_sel_t                   sel;
    logic [DATAWIDTH_CSADDR-1:0] decode_addr;
    logic [DATAWIDTH_CSADDR-1:0] incr_addr;
    logic                        incr_carry;

    sc_cs_branch_eval u_branch_eval (
        .cond        (bus.CSSEQ_COND_InBUS),
        .flags       (bus.CSSEQ_FLAGS_InBUS),
        .ir_bit13    (bus.CSSEQ_IR_InBUS[13]),
        .ir_class    (bus.CSSEQ_IR_InBUS[31:30]),
        .ir_op       (bus.CSSEQ_IR_InBUS[24:19]),
        .sel         (sel),
        .decode_addr (decode_addr)
    );

    // State register
    always_ff @(posedge SC_CSSEQ_CLOCK_50) begin
        if (SC_CSSEQ_RESET_InHigh) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: TRAP outranks HALT, and HALT outranks START while halted
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.CSSEQ_START_InHigh) state_next = ST_RUN;
            ST_RUN: begin
                if (bus.CSSEQ_TRAP_InHigh)      state_next = ST_RUN;
                else if (bus.CSSEQ_HALT_InHigh) state_next = ST_HALT;
            end
            ST_HALT: begin
                if (bus.CSSEQ_TRAP_InHigh)       state_next = ST_RUN;
                else if (bus.CSSEQ_HALT_InHigh)  state_next = ST_HALT;
                else if (bus.CSSEQ_START_InHigh) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/action decode
    always_comb begin
        load_zero = 1'b0;
        load_trap = 1'b0;
        load_seq  = 1'b0;
        count_en  = 1'b0;
        valid     = (state_reg == ST_RUN);
        case (state_reg)
            ST_IDLE: load_zero = bus.CSSEQ_START_InHigh;
            ST_RUN: begin
                if (bus.CSSEQ_TRAP_InHigh) begin
                    load_trap = 1'b1;
                end else if (!bus.CSSEQ_HALT_InHigh && !bus.CSSEQ_STALL_InHigh) begin
                    load_seq = 1'b1;
                    count_en = 1'b1;
                end
            end
            ST_HALT: load_trap = bus.CSSEQ_TRAP_InHigh;
            default: ;
        endcase
    end

    assign {incr_carry, incr_addr} = {1'b0, csaddr_reg} + {{DATAWIDTH_CSADDR{1'b0}}, 1'b1};

    always_comb begin
        csaddr_next = csaddr_reg;
        if (load_zero) begin
            csaddr_next = '0;
        end else if (load_trap) begin
            csaddr_next = TRAP_VECTOR;
        end else if (load_seq) begin
            if (sel.sel_decode)    csaddr_next = decode_addr;
            else if (sel.sel_jump) csaddr_next = bus.CSSEQ_JUMPADDR_InBUS;
            else                   csaddr_next = incr_addr;
        end
    end

    always_ff @(posedge SC_CSSEQ_CLOCK_50) begin
        if (SC_CSSEQ_RESET_InHigh) begin
            csaddr_reg <= '0;
            wrap_reg   <= 1'b0;
            count_reg  <= '0;
        end else begin
            csaddr_reg <= csaddr_next;
            if (load_seq && sel.sel_next && incr_carry) begin
                wrap_reg <= 1'b1;
            end
            if (count_en && (count_reg != {DATAWIDTH_COUNT{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign bus.CSSEQ_CSADDR_OutBUS = csaddr_reg;
    assign bus.CSSEQ_VALID_OutHigh = valid;
    assign bus.CSSEQ_STATE_OutBUS  = state_reg;
    assign bus.CSSEQ_WRAP_OutHigh  = wrap_reg;
    assign bus.CSSEQ_COUNT_OutBUS  = count_reg;

endmodule

// File: tb/tb_sc_cs_sequencer.sv
// Directed bench for sc_cs_sequencer: main 16-bit instance plus a narrow-counter
// instance so counter saturation is reachable in a few cycles.
module tb_sc_cs_sequencer;

    logic SC_CSSEQ_CLOCK_50 = 1'b0;
    logic srst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 SC_CSSEQ_CLOCK_50 = ~SC_CSSEQ_CLOCK_50;

    sc_cs_sequencer_if #(.CSADDR_W(11), .COUNT_W(16)) bus ();
    sc_cs_sequencer_if #(.CSADDR_W(11), .COUNT_W(4))  bus_sat ();

    sc_cs_sequencer #(.DATAWIDTH_CSADDR(11), .DATAWIDTH_COUNT(16), .TRAP_VECTOR(11'h7F0)) dut (
        .SC_CSSEQ_CLOCK_50     (SC_CSSEQ_CLOCK_50),
        .SC_CSSEQ_RESET_InHigh (srst),
        .bus                   (bus.slave)
    );

    sc_cs_sequencer #(.DATAWIDTH_CSADDR(11), .DATAWIDTH_COUNT(4), .TRAP_VECTOR(11'h7F0)) dut_sat (
        .SC_CSSEQ_CLOCK_50     (SC_CSSEQ_CLOCK_50),
        .SC_CSSEQ_RESET_InHigh (srst),
        .bus                   (bus_sat.slave)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge SC_CSSEQ_CLOCK_50);
        #1;
    endtask

    task automatic expect_main(input string tag, input logic [1:0] st, input logic [10:0] addr,
                               input logic vld, input logic wrp, input logic [15:0] cnt);
        check_value({tag, ".state"},  32'(bus.CSSEQ_STATE_OutBUS),  32'(st));
        check_value({tag, ".csaddr"}, 32'(bus.CSSEQ_CSADDR_OutBUS), 32'(addr));
        check_value({tag, ".valid"},  32'(bus.CSSEQ_VALID_OutHigh), 32'(vld));
        check_value({tag, ".wrap"},   32'(bus.CSSEQ_WRAP_OutHigh),  32'(wrp));
        check_value({tag, ".count"},  32'(bus.CSSEQ_COUNT_OutBUS),  32'(cnt));
    endtask

    task automatic drive(input logic st, input logic hl, input logic tr, input logic sl,
                         input logic [2:0] cond, input logic [10:0] jmp,
                         input logic [31:0] ir, input logic [3:0] flags);
        bus.CSSEQ_START_InHigh   = st;
        bus.CSSEQ_HALT_InHigh    = hl;
        bus.CSSEQ_TRAP_InHigh    = tr;
        bus.CSSEQ_STALL_InHigh   = sl;
        bus.CSSEQ_COND_InBUS     = cond;
        bus.CSSEQ_JUMPADDR_InBUS = jmp;
        bus.CSSEQ_IR_InBUS       = ir;
        bus.CSSEQ_FLAGS_InBUS    = flags;
    endtask

    initial begin
        logic [31:0] ir;
        drive(0, 0, 0, 0, 3'b000, 11'h0, 32'h0, 4'h0);
        bus_sat.CSSEQ_START_InHigh   = 1'b0;
        bus_sat.CSSEQ_HALT_InHigh    = 1'b0;
        bus_sat.CSSEQ_TRAP_InHigh    = 1'b0;
        bus_sat.CSSEQ_STALL_InHigh   = 1'b0;
        bus_sat.CSSEQ_COND_InBUS     = 3'b000;
        bus_sat.CSSEQ_JUMPADDR_InBUS = 11'h0;
        bus_sat.CSSEQ_IR_InBUS       = 32'h0;
        bus_sat.CSSEQ_FLAGS_InBUS    = 4'h0;

        // Reset state
        step(); step();
        expect_main("reset", 2'd0, 11'h0, 1'b0, 1'b0, 16'd0);
        srst = 1'b0;

        // Idle ignores sequencing inputs
        drive(0, 0, 0, 0, 3'b110, 11'h055, 32'h0, 4'h0);
        step();
        expect_main("idle_hold", 2'd0, 11'h0, 1'b0, 1'b0, 16'd0);

        // Start, then three NEXT cycles
        drive(1, 0, 0, 0, 3'b110, 11'h055, 32'h0, 4'h0);
        step();
        expect_main("start", 2'd1, 11'h0, 1'b1, 1'b0, 16'd0);
        drive(0, 0, 0, 0, 3'b000, 11'h0, 32'h0, 4'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_value($sformatf("next%0d.csaddr", i), 32'(bus.CSSEQ_CSADDR_OutBUS), 32'(i));
        end
        check_value("next3.count", 32'(bus.CSSEQ_COUNT_OutBUS), 32'd3);
        check_value("next3.valid", 32'(bus.CSSEQ_VALID_OutHigh), 32'd1);

        // Conditional branches: Z taken / not taken from address 10
        drive(0, 0, 0, 0, 3'b110, 11'd10, 32'h0, 4'h0);
        step();
        check_value("jump10", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'd10);
        drive(0, 0, 0, 0, 3'b010, 11'd200, 32'h0, 4'b0100);
        step();
        check_value("brz_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'd200);
        drive(0, 0, 0, 0, 3'b110, 11'd10, 32'h0, 4'h0);
        step();
        drive(0, 0, 0, 0, 3'b010, 11'd200, 32'h0, 4'b1011);
        step();
        check_value("brz_not_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'd11);
        check_value("brz_count", 32'(bus.CSSEQ_COUNT_OutBUS), 32'd7);

        drive(0, 0, 0, 0, 3'b001, 11'h123, 32'h0, 4'b1000);
        step();
        check_value("brn_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h123);
        drive(0, 0, 0, 0, 3'b011, 11'h456, 32'h0, 4'b1101);
        step();
        check_value("brv_not_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h124);
        drive(0, 0, 0, 0, 3'b100, 11'h055, 32'h0, 4'b0001);
        step();
        check_value("brc_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h055);
        drive(0, 0, 0, 0, 3'b101, 11'h300, 32'h0000_2000, 4'h0);
        step();
        check_value("brir_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h300);
        drive(0, 0, 0, 0, 3'b101, 11'h400, 32'hFFFF_DFFF, 4'hF);
        step();
        check_value("brir_not_taken", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h301);

        // Decode: {1, IR[31:30], IR[24:19], 00}
        ir = 32'h0;
        ir[31:30] = 2'b10;
        ir[24:19] = 6'h3C;
        drive(0, 0, 0, 0, 3'b111, 11'h111, ir, 4'hF);
        step();
        check_value("decode_10_3c", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h6F0);
        ir[31:30] = 2'b01;
        drive(0, 0, 0, 0, 3'b111, 11'h111, ir, 4'hF);
        step();
        check_value("decode_01_3c", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'h5F0);
        check_value("decode_count", 32'(bus.CSSEQ_COUNT_OutBUS), 32'd14);

        // Stall x2, halt, halt+start, start
        drive(0, 0, 0, 1, 3'b110, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("stall1", 2'd1, 11'h5F0, 1'b1, 1'b0, 16'd14);
        step();
        expect_main("stall2", 2'd1, 11'h5F0, 1'b1, 1'b0, 16'd14);
        drive(0, 1, 0, 0, 3'b110, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("halt", 2'd2, 11'h5F0, 1'b0, 1'b0, 16'd14);
        drive(1, 1, 0, 0, 3'b110, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("halt_start", 2'd2, 11'h5F0, 1'b0, 1'b0, 16'd14);
        drive(1, 0, 0, 0, 3'b110, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("resume", 2'd1, 11'h5F0, 1'b1, 1'b0, 16'd14);
        drive(0, 0, 0, 0, 3'b000, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("resume_next", 2'd1, 11'h5F1, 1'b1, 1'b0, 16'd15);

        // Trap beats halt in RUN; trap also wakes HALT
        drive(0, 1, 1, 1, 3'b110, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("trap_halt_run", 2'd1, 11'h7F0, 1'b1, 1'b0, 16'd15);
        drive(0, 1, 0, 0, 3'b000, 11'h111, 32'h0, 4'h0);
        step();
        check_value("halt2.state", 32'(bus.CSSEQ_STATE_OutBUS), 32'd2);
        drive(0, 0, 1, 0, 3'b000, 11'h111, 32'h0, 4'h0);
        step();
        expect_main("trap_from_halt", 2'd1, 11'h7F0, 1'b1, 1'b0, 16'd15);

        // Increment wrap 7FF -> 0, sticky
        drive(0, 0, 0, 0, 3'b110, 11'h7FF, 32'h0, 4'h0);
        step();
        expect_main("at_7ff", 2'd1, 11'h7FF, 1'b1, 1'b0, 16'd16);
        drive(0, 0, 0, 0, 3'b000, 11'h0, 32'h0, 4'h0);
        step();
        expect_main("wrap", 2'd1, 11'h000, 1'b1, 1'b1, 16'd17);
        step();
        expect_main("wrap_sticky", 2'd1, 11'h001, 1'b1, 1'b1, 16'd18);

        // Reset mid-RUN at address 300
        drive(0, 0, 0, 0, 3'b110, 11'd300, 32'h0, 4'h0);
        step();
        check_value("at_300", 32'(bus.CSSEQ_CSADDR_OutBUS), 32'd300);
        drive(0, 0, 0, 0, 3'b000, 11'h0, 32'h0, 4'h0);
        srst = 1'b1;
        step();
        expect_main("reset_mid_run", 2'd0, 11'h0, 1'b0, 1'b0, 16'd0);
        srst = 1'b0;

        // Counter saturation on the 4-bit instance
        bus_sat.CSSEQ_START_InHigh = 1'b1;
        step();
        bus_sat.CSSEQ_START_InHigh = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_value("sat.count15", 32'(bus_sat.CSSEQ_COUNT_OutBUS), 32'd15);
        step();
        step();
        check_value("sat.count_hold", 32'(bus_sat.CSSEQ_COUNT_OutBUS), 32'd15);
        check_value("sat.csaddr", 32'(bus_sat.CSSEQ_CSADDR_OutBUS), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
